// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the 37-bit carry-select adder and the accumulation
// stage wrapped around it.
//   ADD_WIDTH   : operand / sum width of the adder and accumulator
//   acc_state_t : accumulator FSM states (2-bit encoding)
// ----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADD_WIDTH = 37;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for the first operand of a result
        ACCUM = 2'd1,   // summing the remaining operands
        DONE  = 2'd2    // result presented, waiting for downstream
    } acc_state_t;

    // Width needed to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder_accum_37bit_if.sv
// ----------------------------------------------------------------------------
// adder_accum_37bit_if
// Operand/result handshake bundle for the accumulation stage.
//   i_clear                  : synchronous abort
//   i_op_valid/o_op_ready    : operand handshake, i_op carries the operand
//   o_res_valid/i_res_ready  : result handshake
//   o_result, o_overflow     : accumulated sum and sticky carry-out flag
//   o_count, o_busy          : progress status
// Modports: master drives operands and takes results; slave is the
// accumulator itself.
// ----------------------------------------------------------------------------
interface adder_accum_37bit_if
    import adder_pkg::*;
#(
    parameter int WIDTH     = ADD_WIDTH,
    parameter int NUM_TERMS = 8
);
    localparam int CNT_W = cnt_width(NUM_TERMS);

    logic             i_clear;
    logic             i_op_valid;
    logic             o_op_ready;
    logic [WIDTH-1:0] i_op;
    logic             o_res_valid;
    logic             i_res_ready;
    logic [WIDTH-1:0] o_result;
    logic             o_overflow;
    logic [CNT_W-1:0] o_count;
    logic             o_busy;

    modport master (
        output i_clear, i_op_valid, i_op, i_res_ready,
        input  o_op_ready, o_res_valid, o_result, o_overflow, o_count, o_busy
    );

    modport slave (
        input  i_clear, i_op_valid, i_op, i_res_ready,
        output o_op_ready, o_res_valid, o_result, o_overflow, o_count, o_busy
    );

endinterface

// File: rtl/csa_37bit.sv
// ----------------------------------------------------------------------------
// csa_37bit
// Combinational 37-bit carry-select adder.
//   i_a, i_b : addends
//   i_cin    : carry in
//   o_sum    : i_a + i_b + i_cin, modulo 2^37
//   o_cout   : carry out of bit 36
// Structure: a 5-bit ripple block on the low bits, then four 8-bit blocks
// that each precompute the sum for carry-in 0 and 1 and select with the
// carry arriving from below, so the critical path is one block plus a mux
// chain rather than a full 37-bit ripple.
// ----------------------------------------------------------------------------
module csa_37bit
    import adder_pkg::*;
(
    input  logic [ADD_WIDTH-1:0] i_a,
    input  logic [ADD_WIDTH-1:0] i_b,
    input  logic                 i_cin,
    output logic [ADD_WIDTH-1:0] o_sum,
    output logic                 o_cout
);

    localparam int FIRST_W = 5;
    localparam int BLK_W   = 8;
    localparam int NUM_BLK = (ADD_WIDTH - FIRST_W) / BLK_W;

    // w_carry[g] is the carry into select block g.
    logic [NUM_BLK:0] w_carry;

    assign {w_carry[0], o_sum[FIRST_W-1:0]} =
        {1'b0, i_a[FIRST_W-1:0]} + {1'b0, i_b[FIRST_W-1:0]} + {{FIRST_W{1'b0}}, i_cin};

    for (genvar g = 0; g < NUM_BLK; g++) begin : g_blk
        localparam int LO = FIRST_W + g * BLK_W;

        logic [BLK_W:0] w_sum0;
        logic [BLK_W:0] w_sum1;

        // Both candidate sums are formed in parallel, independent of the
        // incoming carry.
        assign w_sum0 = {1'b0, i_a[LO +: BLK_W]} + {1'b0, i_b[LO +: BLK_W]};
        assign w_sum1 = {1'b0, i_a[LO +: BLK_W]} + {1'b0, i_b[LO +: BLK_W]}
                        + {{BLK_W{1'b0}}, 1'b1};

        assign o_sum[LO +: BLK_W] = w_carry[g] ? w_sum1[BLK_W-1:0] : w_sum0[BLK_W-1:0];
        assign w_carry[g+1]       = w_carry[g] ? w_sum1[BLK_W]     : w_sum0[BLK_W];
    end

    assign o_cout = w_carry[NUM_BLK];

endmodule

// File: rtl/adder_accum_37bit.sv
// ----------------------------------------------------------------------------
// adder_accum_37bit
// Registered accumulation loop around csa_37bit: sums NUM_TERMS operands
// taken over a valid/ready handshake and presents the total, with a sticky
// carry-out flag, on a valid/ready result port.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : slave side of adder_accum_37bit_if (operands, result, status)
// Flow: IDLE takes the first operand (adder term1 forced to 0), ACCUM adds
// the rest, DONE holds the result until i_res_ready. All outputs decode from
// registers only.
// ----------------------------------------------------------------------------
module adder_accum_37bit
    import adder_pkg::*;
#(
    parameter  int NUM_TERMS = 8,
    localparam int WIDTH     = ADD_WIDTH,
    localparam int CNT_W     = cnt_width(NUM_TERMS)
)(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    adder_accum_37bit_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS);

    acc_state_t       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    acc_state_t       w_state_next;
    logic [WIDTH-1:0] w_acc_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_overflow_next;

    logic [WIDTH-1:0] w_term1;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_op_ready;
    logic             w_accept;
    logic [CNT_W-1:0] w_count_inc;

    // ------------------------------------------------------------------
    // Feedback adder. In IDLE the first operand passes straight through,
    // so no separate clear of acc is needed before a new result.
    // ------------------------------------------------------------------
    assign w_term1 = (r_state == IDLE) ? '0 : r_acc;

    csa_37bit u_csa (
        .i_a    (w_term1),
        .i_b    (bus.i_op),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Ready depends on registered state only, never on i_res_ready.
    assign w_op_ready  = (r_state != DONE);
    assign w_accept    = bus.i_op_valid & w_op_ready;
    assign w_count_inc = r_count + CNT_W'(1);

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_next    = r_state;
        w_acc_next      = r_acc;
        w_count_next    = r_count;
        w_overflow_next = r_overflow;

        if (bus.i_clear) begin
            // Abort wins over everything: a same-cycle operand is dropped
            // and a pending result is discarded.
            w_state_next    = IDLE;
            w_acc_next      = '0;
            w_count_next    = '0;
            w_overflow_next = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_acc_next      = w_sum;
                        w_count_next    = CNT_W'(1);
                        w_overflow_next = 1'b0;
                        w_state_next    = (NUM_TERMS == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        w_acc_next      = w_sum;
                        w_count_next    = w_count_inc;
                        w_overflow_next = r_overflow | w_cout;
                        if (w_count_inc == LAST_CNT) begin
                            w_state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.i_res_ready) begin
                        w_state_next    = IDLE;
                        w_acc_next      = '0;
                        w_count_next    = '0;
                        w_overflow_next = 1'b0;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean idle.
                    w_state_next    = IDLE;
                    w_acc_next      = '0;
                    w_count_next    = '0;
                    w_overflow_next = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would make update order matter.
            r_state    <= w_state_next;
            r_acc      <= w_acc_next;
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registers
    // ------------------------------------------------------------------
    assign bus.o_op_ready  = w_op_ready;
    assign bus.o_res_valid = (r_state == DONE);
    assign bus.o_result    = r_acc;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_count     = r_count;
    assign bus.o_busy      = (r_state != IDLE);

endmodule
